dcr_master: RTL and testbench

DCR_MASTER -- requirements
Module: dcr_master

---
 rtl/dcr_master.sv | 171 +++++++++++++++++
 tb/tb_dcr_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcr_master.sv
// dcr_master: command-driven register-bus master that runs WRITE, READ,
// POLL and WAIT_IRQ commands and returns one response per command.
// Ports:
//   sys_clk, sys_rst                      clock, async active-high reset
//   cmd_valid/ready/op/addr/wdata/mask    command handshake and fields
//   rsp_valid/ready/rdata/err             response handshake and fields
//   address/write/writedata/readdata      register bus (1-cycle read latency)
//   irq                                   level interrupt from the slave
module dcr_master #(
  parameter int unsigned C_POLL_LIMIT = 16,
  parameter int unsigned C_IRQ_LIMIT  = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [31:0] cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  address,
  output logic        write,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        irq
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR       = 3'd1;
  localparam logic [2:0] S_RD_ADDR  = 3'd2;
  localparam logic [2:0] S_RD_WAIT  = 3'd3;
  localparam logic [2:0] S_IRQ_WAIT = 3'd4;
  localparam logic [2:0] S_RESP     = 3'd5;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  // Timeout fires on the attempt that would bring the count to the limit.
  localparam logic [15:0] POLL_LAST = 16'(C_POLL_LIMIT - 1);
  localparam logic [15:0] IRQ_LAST  = 16'(C_IRQ_LIMIT - 1);

  logic [2:0]  state, state_n;
  logic [1:0]  op_q;
  logic [5:0]  addr_q;
  logic [31:0] wdata_q, mask_q;
  logic [15:0] poll_cnt, poll_cnt_n;
  logic [15:0] irq_cnt, irq_cnt_n;
  logic [31:0] rdata_n;
  logic        err_n;
  logic        accept;
  logic [5:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_st;
  logic        match;

  assign accept = (state == S_IDLE) && cmd_valid && cmd_ready;

  // Outputs are registered from the next state, so on acceptance the
  // bus must see the incoming command fields rather than the latches.
  assign bus_addr  = accept ? cmd_addr  : addr_q;
  assign bus_wdata = accept ? cmd_wdata : wdata_q;
  assign bus_addr_st = (state_n == S_WR) || (state_n == S_RD_ADDR) ||
                       (state_n == S_RD_WAIT);

  assign match = ((readdata ^ wdata_q) & mask_q) == 32'd0;

  always_comb begin
    state_n    = state;
    poll_cnt_n = poll_cnt;
    irq_cnt_n  = irq_cnt;
    rdata_n    = rsp_rdata;
    err_n      = rsp_err;
    case (state)
      S_IDLE: begin
        if (accept) begin
          poll_cnt_n = 16'd0;
          irq_cnt_n  = 16'd0;
          unique case (cmd_op)
            OP_WRITE: state_n = S_WR;
            OP_READ,
            OP_POLL:  state_n = S_RD_ADDR;
            default:  state_n = S_IRQ_WAIT;
          endcase
        end
      end
      S_WR: begin
        state_n = S_RESP;
        rdata_n = 32'd0;
        err_n   = 1'b0;
      end
      S_RD_ADDR: state_n = S_RD_WAIT;
      S_RD_WAIT: begin
        rdata_n = readdata;
        err_n   = 1'b0;
        if (op_q == OP_READ || match) begin
          state_n = S_RESP;
        end else begin
          poll_cnt_n = poll_cnt + 16'd1;
          if (poll_cnt == POLL_LAST) begin
            state_n = S_RESP;
            err_n   = 1'b1;
          end else begin
            state_n = S_RD_ADDR;
          end
        end
      end
      S_IRQ_WAIT: begin
        rdata_n = 32'd0;
        err_n   = 1'b0;
        if (irq) begin
          state_n = S_RESP;
        end else if (irq_cnt == IRQ_LAST) begin
          state_n = S_RESP;
          err_n   = 1'b1;
        end else begin
          irq_cnt_n = irq_cnt + 16'd1;
        end
      end
      S_RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_n = S_IDLE;
          rdata_n = 32'd0;
          err_n   = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      op_q      <= 2'b00;
      addr_q    <= 6'd0;
      wdata_q   <= 32'd0;
      mask_q    <= 32'd0;
      poll_cnt  <= 16'd0;
      irq_cnt   <= 16'd0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      address   <= 6'd0;
      write     <= 1'b0;
      writedata <= 32'd0;
    end else begin
      state     <= state_n;
      poll_cnt  <= poll_cnt_n;
      irq_cnt   <= irq_cnt_n;
      if (accept) begin
        op_q    <= cmd_op;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        mask_q  <= cmd_mask;
      end
      cmd_ready <= (state_n == S_IDLE);
      rsp_valid <= (state_n == S_RESP);
      rsp_rdata <= rdata_n;
      rsp_err   <= err_n;
      address   <= bus_addr_st ? bus_addr : 6'd0;
      write     <= (state_n == S_WR);
      writedata <= (state_n == S_WR) ? bus_wdata : 32'd0;
    end
  end

endmodule

// File: tb/tb_dcr_master.sv
// tb_dcr_master: directed bench for dcr_master with a small register
// slave model; immediate assertions at every comparison point.
module tb_dcr_master;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] cmd_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [5:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata = 32'd0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  int wr_count = 0;
  int addr_cycles = 0;
  int poll_base = 0;
  int poll_mode = 0;
  logic [5:0]  last_wr_addr = 6'd0;
  logic [31:0] last_wr_data = 32'd0;

  always #5 sys_clk = ~sys_clk;

  dcr_master #(.C_POLL_LIMIT(4), .C_IRQ_LIMIT(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .address(address), .write(write), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  // Slave: 0xDEADBEEF at 0x04; status reg at 0x10 whose bit30 clears
  // from the 3rd read on (mode 0) or never (mode 1).
  always @(posedge sys_clk) begin
    if (write) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= address;
      last_wr_data <= writedata;
    end
    if (address == 6'h10 && !write) addr_cycles <= addr_cycles + 1;
    if (address == 6'h04)
      readdata <= 32'hDEAD_BEEF;
    else if (address == 6'h10)
      readdata <= (poll_mode == 0 && addr_cycles - poll_base >= 4) ?
                  32'h0000_0055 : 32'h4000_0055;
    else
      readdata <= {26'd0, address};
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] a,
                      input logic [31:0] wd, input logic [31:0] m);
    chk("cmd_ready_before", {31'd0, cmd_ready}, 32'd1);
    cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = m;
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin
      tick;
      cyc++;
    end
    chk("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic finish_rsp;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int c;
    int wc0;
    logic [31:0] hold_rdata;
    sys_rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 6'd0;
    cmd_wdata = 32'd0; cmd_mask = 32'd0;
    rsp_ready = 1'b0; irq = 1'b0;
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_address", {26'd0, address}, 32'd0);
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    tick; tick;
    sys_rst = 1'b0;
    chk("cmd_ready_pre", {31'd0, cmd_ready}, 32'd0);
    tick;
    chk("cmd_ready_post_rst", {31'd0, cmd_ready}, 32'd1);

    // WRITE
    send(2'b00, 6'h08, 32'h1234_5678, 32'd0);
    chk("wr_strobe", {31'd0, write}, 32'd1);
    chk("wr_address", {26'd0, address}, 32'h08);
    chk("wr_data", writedata, 32'h1234_5678);
    tick;
    chk("wr_strobe_off", {31'd0, write}, 32'd0);
    chk("wr_address_idle", {26'd0, address}, 32'd0);
    chk("wr_data_idle", writedata, 32'd0);
    chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    chk("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("wr_count", wr_count, 32'd1);
    chk("wr_last_addr", {26'd0, last_wr_addr}, 32'h08);
    chk("wr_last_data", last_wr_data, 32'h1234_5678);
    finish_rsp;

    // READ with 10 cycles of response backpressure
    wc0 = wr_count;
    send(2'b01, 6'h04, 32'd0, 32'd0);
    chk("rd_address", {26'd0, address}, 32'h04);
    wait_rsp(c);
    chk("rd_latency", c, 32'd2);
    chk("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_err", {31'd0, rsp_err}, 32'd0);
    chk("rd_no_write", wr_count, wc0);
    hold_rdata = rsp_rdata;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, hold_rdata);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    finish_rsp;

    // POLL match on the 3rd read
    poll_mode = 0;
    poll_base = addr_cycles;
    send(2'b10, 6'h10, 32'd0, 32'h4000_0000);
    wait_rsp(c);
    chk("poll_err", {31'd0, rsp_err}, 32'd0);
    chk("poll_rdata", rsp_rdata, 32'h0000_0055);
    chk("poll_reads", (addr_cycles - poll_base) / 2, 32'd3);
    finish_rsp;

    // POLL timeout at limit 4
    poll_mode = 1;
    poll_base = addr_cycles;
    send(2'b10, 6'h10, 32'd0, 32'h4000_0000);
    wait_rsp(c);
    chk("pto_err", {31'd0, rsp_err}, 32'd1);
    chk("pto_rdata", rsp_rdata, 32'h4000_0055);
    chk("pto_reads", (addr_cycles - poll_base) / 2, 32'd4);
    finish_rsp;

    // POLL with zero mask matches on the first read
    poll_base = addr_cycles;
    send(2'b10, 6'h10, 32'hFFFF_FFFF, 32'd0);
    wait_rsp(c);
    chk("pm0_latency", c, 32'd2);
    chk("pm0_err", {31'd0, rsp_err}, 32'd0);
    chk("pm0_rdata", rsp_rdata, 32'h4000_0055);
    chk("pm0_reads", (addr_cycles - poll_base) / 2, 32'd1);
    finish_rsp;

    // WAIT_IRQ with irq pulsed in the 5th wait cycle
    send(2'b11, 6'h3F, 32'hFFFF_FFFF, 32'd0);
    chk("irq_address", {26'd0, address}, 32'd0);
    chk("irq_write", {31'd0, write}, 32'd0);
    repeat (4) tick;
    chk("irq_not_done", {31'd0, rsp_valid}, 32'd0);
    irq = 1'b1;
    tick;
    irq = 1'b0;
    chk("irq_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("irq_err", {31'd0, rsp_err}, 32'd0);
    chk("irq_rdata", rsp_rdata, 32'd0);
    finish_rsp;

    // WAIT_IRQ timeout after 8 cycles
    send(2'b11, 6'h00, 32'd0, 32'd0);
    wait_rsp(c);
    chk("ito_cycles", c, 32'd8);
    chk("ito_err", {31'd0, rsp_err}, 32'd1);
    chk("ito_rdata", rsp_rdata, 32'd0);
    finish_rsp;

    // WAIT_IRQ with irq already high
    irq = 1'b1;
    send(2'b11, 6'h00, 32'd0, 32'd0);
    wait_rsp(c);
    irq = 1'b0;
    chk("ihi_cycles", c, 32'd1);
    chk("ihi_err", {31'd0, rsp_err}, 32'd0);
    finish_rsp;

    // Reset during RD_WAIT
    send(2'b01, 6'h04, 32'd0, 32'd0);
    tick;
    chk("mid_address", {26'd0, address}, 32'h04);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("mr_address", {26'd0, address}, 32'd0);
    chk("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("mr_write", {31'd0, write}, 32'd0);
    chk("mr_rdata", rsp_rdata, 32'd0);
    tick; tick;
    chk("mr_hold_valid", {31'd0, rsp_valid}, 32'd0);
    sys_rst = 1'b0;
    tick;
    chk("mr_cmd_ready_up", {31'd0, cmd_ready}, 32'd1);
    repeat (3) tick;
    chk("mr_no_rsp", {31'd0, rsp_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
